// File: rtl/hdc_classify_ctrl_if.sv
// hdc_classify_ctrl_if: host/memory/datapath signals seen by the HDC classification sequencer
interface hdc_classify_ctrl_if #(
   parameter int WW = 10
);
   logic start;
   logic [7:0] length;
   logic [7:0] chr_addr;
   logic [7:0] chr_data;
   logic [2:0] dp_op;
   logic [WW-1:0] dp_word;
   logic [5:0] dp_token;
   logic dp_last;
   logic signed [23:0] thr_sum;
   logic signed [23:0] dp_wsum;
   logic [4:0] ham_pop;
   logic [4:0] spam_pop;
   logic busy;
   logic done;
   logic [1:0] result;
   modport master (
      output start, length, chr_data, dp_wsum, ham_pop, spam_pop,
      input chr_addr, dp_op, dp_word, dp_token, dp_last, thr_sum, busy, done, result
   );
   modport slave (
      input start, length, chr_data, dp_wsum, ham_pop, spam_pop,
      output chr_addr, dp_op, dp_word, dp_token, dp_last, thr_sum, busy, done, result
   );
endinterface

// File: rtl/hdc_classify_ctrl.sv
// hdc_classify_ctrl: tokenizes a message and sequences the HDC datapath into a ham/spam/tie decision
module hdc_classify_ctrl #(
   parameter int DIM = 10000,
   parameter int LANES = 16,
   parameter int MAX_LENGTH = 200,
   parameter int NUM_CHAR = 37,
   parameter int DP_LAT = 2
)(
   input logic clk,
   input logic reset,
   hdc_classify_ctrl_if.slave bus
);
   localparam int WORDS = DIM / LANES;
   localparam int WW = WORDS > 1 ? $clog2(WORDS) : 1;
   localparam int TW = $clog2(NUM_CHAR);
   localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, ADD = 3'd2, THR = 3'd3, CMP = 3'd4;
   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_FETCH0, S_FETCH1, S_ADD, S_WDRAIN, S_THR, S_CMP, S_CDRAIN, S_DONE
   } state_e;
   state_e state_q;
   logic [7:0] len_q, idx_q, addr_q, drain_q, lc;
   logic [WW-1:0] word_q;
   logic [2:0] op_q;
   logic last_q, busy_q, done_q, word_end, drain_end;
   logic [1:0] result_q;
   logic [TW-1:0] token_q, token_d;
   logic signed [23:0] thr_q, thr_d;
   logic [13:0] ham_q, spam_q, ham_d, spam_d;
   logic [DP_LAT-1:0] wv_q, cv_q;
   always_comb begin
      lc = (bus.chr_data >= "A" && bus.chr_data <= "Z") ? bus.chr_data | 8'h20 : bus.chr_data;
      token_d = (lc >= "a" && lc <= "z") ? TW'(lc - "a" + 8'd11) :
                (lc >= "0" && lc <= "9") ? TW'(lc - "0" + 8'd1) : '0;
      thr_d = thr_q + (wv_q[DP_LAT-1] ? bus.dp_wsum : 24'sd0);
      ham_d = ham_q + (cv_q[DP_LAT-1] ? 14'(bus.ham_pop) : 14'd0);
      spam_d = spam_q + (cv_q[DP_LAT-1] ? 14'(bus.spam_pop) : 14'd0);
      word_end = word_q == WW'(WORDS - 1);
      drain_end = drain_q == 8'(DP_LAT - 1);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q <= '0;
         idx_q <= '0;
         addr_q <= '0;
         drain_q <= '0;
         word_q <= '0;
         op_q <= NOP;
         last_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         result_q <= 2'b11;
         token_q <= '0;
         thr_q <= '0;
         ham_q <= '0;
         spam_q <= '0;
         wv_q <= '0;
         cv_q <= '0;
      end else begin
         // valid-return trackers: a bit reaches the top exactly DP_LAT cycles after its op
         wv_q <= (wv_q << 1) | DP_LAT'(op_q == ADD && last_q);
         cv_q <= (cv_q << 1) | DP_LAT'(op_q == CMP);
         thr_q <= thr_d;
         ham_q <= ham_d;
         spam_q <= spam_d;
         done_q <= 1'b0;
         drain_q <= drain_q + 8'd1;
         word_q <= (op_q == NOP || word_end) ? '0 : word_q + WW'(1);
         case (state_q)
            S_IDLE: if (bus.start) begin
               state_q <= S_CLR;
               op_q <= CLR;
               busy_q <= 1'b1;
               len_q <= bus.length > 8'(MAX_LENGTH) ? 8'(MAX_LENGTH) : bus.length;
               thr_q <= '0;
               ham_q <= '0;
               spam_q <= '0;
            end
            S_CLR: if (word_end) begin
               op_q <= NOP;
               idx_q <= '0;
               addr_q <= '0;
               state_q <= len_q != 8'd0 ? S_FETCH0 : S_DONE;
               done_q <= len_q == 8'd0;
               result_q <= 2'b11;
            end
            S_FETCH0: state_q <= S_FETCH1;
            S_FETCH1: begin
               state_q <= S_ADD;
               op_q <= ADD;
               token_q <= token_d;
               last_q <= idx_q == len_q - 8'd1;
            end
            S_ADD: if (word_end) begin
               op_q <= NOP;
               last_q <= 1'b0;
               drain_q <= '0;
               idx_q <= idx_q + 8'd1;
               addr_q <= idx_q + 8'd1;
               state_q <= last_q ? S_WDRAIN : S_FETCH0;
            end
            S_WDRAIN: if (drain_end) begin
               state_q <= S_THR;
               op_q <= THR;
            end
            S_THR: if (word_end) begin
               state_q <= S_CMP;
               op_q <= CMP;
            end
            S_CMP: if (word_end) begin
               state_q <= S_CDRAIN;
               op_q <= NOP;
               drain_q <= '0;
            end
            S_CDRAIN: if (drain_end) begin
               state_q <= S_DONE;
               done_q <= 1'b1;
               result_q <= ham_d < spam_d ? 2'b01 : ham_d > spam_d ? 2'b00 : 2'b11;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
   assign bus.chr_addr = addr_q;
   assign bus.dp_op = op_q;
   assign bus.dp_word = word_q;
   assign bus.dp_token = token_q;
   assign bus.dp_last = last_q;
   assign bus.thr_sum = thr_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_hdc_classify_ctrl.sv
// tb_hdc_classify_ctrl: randomized bench with a message buffer and delayed-return datapath model
module tb_hdc_classify_ctrl;
   localparam int DIM = 64, LANES = 16, W = DIM / LANES, D = 2, MAXL = 200, RND = 9999;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   hdc_classify_ctrl_if #(.WW(2)) bus ();
   hdc_classify_ctrl #(.DIM(DIM), .LANES(LANES), .MAX_LENGTH(MAXL), .NUM_CHAR(37), .DP_LAT(D))
      dut (.clk(clk), .reset(reset), .bus(bus));
   int n_chk, n_fail, cyc = 16, t0, done_cnt, done_cyc, g_wv, g_hp, g_sp, prev_op, prev_word;
   logic [1:0] done_res;
   longint exp_thr, exp_ham, exp_spam;
   logic [7:0] mem [256];
   logic [7:0] prev_addr = 8'd0;
   int tok_q[$], lst_q[$];
   logic [2:0] h_op [8];
   logic h_last [8];
   task automatic check(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask
   function automatic int tok(input logic [7:0] c);
      if (c >= "A" && c <= "Z") return int'(c) - int'("A") + 11;
      if (c >= "a" && c <= "z") return int'(c) - int'("a") + 11;
      if (c >= "0" && c <= "9") return int'(c) - int'("0") + 1;
      return 0;
   endfunction
   // message buffer with one-cycle read latency, datapath returning DP_LAT cycles after each op
   always @(negedge clk) begin
      int p, v, hp, sp;
      cyc++;
      if (!reset && bus.dp_op != 3'd0) check("word", bus.dp_word, bus.dp_op == prev_op ? prev_word + 1 : 0);
      if (!reset && bus.dp_op == 3'd1) check("clr_cycle", bus.dp_word, cyc - t0 - 1);
      if (bus.dp_op == 3'd3) check("thr_sum", bus.thr_sum, exp_thr);
      if (bus.dp_op == 3'd2 && bus.dp_word == 2'd0) begin
         tok_q.push_back(int'(bus.dp_token));
         lst_q.push_back(int'(bus.dp_last));
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc - t0;
         done_res = bus.result;
      end
      h_op[cyc % 8] = bus.dp_op;
      h_last[cyc % 8] = bus.dp_last;
      p = (cyc - D) % 8;
      bus.chr_data = mem[prev_addr];
      prev_addr = bus.chr_addr;
      if (h_op[p] == 3'd2 && h_last[p]) begin
         v = g_wv == RND ? int'($urandom_range(0, 200)) - 100 : g_wv;
         exp_thr += v;
      end else v = int'($urandom);
      bus.dp_wsum = 24'(v);
      if (h_op[p] == 3'd4) begin
         hp = g_hp == RND ? int'($urandom_range(0, 16)) : g_hp;
         sp = g_sp == RND ? int'($urandom_range(0, 16)) : g_sp;
         exp_ham += hp;
         exp_spam += sp;
      end else begin
         hp = int'($urandom_range(0, 31));
         sp = int'($urandom_range(0, 31));
      end
      bus.ham_pop = 5'(hp);
      bus.spam_pop = 5'(sp);
      prev_op = int'(bus.dp_op);
      prev_word = int'(bus.dp_word);
   end
   task automatic load(input string s);
      for (int i = 0; i < 256; i++) mem[i] = i < s.len() ? s[i] : 8'($urandom_range(32, 126));
   endtask
   task automatic check_reset(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_result"}, bus.result, 3);
      check({tag, "_op"}, bus.dp_op, 0);
      check({tag, "_word"}, bus.dp_word, 0);
      check({tag, "_token"}, bus.dp_token, 0);
      check({tag, "_last"}, bus.dp_last, 0);
      check({tag, "_addr"}, bus.chr_addr, 0);
      check({tag, "_thr"}, bus.thr_sum, 0);
   endtask
   task automatic run(input int len, input int wv, input int hp, input int sp, input bit inject);
      int L, d0, exp_done, exp_res;
      bit inj;
      L = len > MAXL ? MAXL : len;
      g_wv = wv;
      g_hp = hp;
      g_sp = sp;
      @(negedge clk); #1;
      exp_thr = 0;
      exp_ham = 0;
      exp_spam = 0;
      tok_q.delete();
      lst_q.delete();
      bus.start = 1'b1;
      bus.length = 8'(len);
      t0 = cyc;
      d0 = done_cnt;
      @(negedge clk); #1;
      bus.start = 1'b0;
      check("busy", bus.busy, 1);
      inj = 1'b0;
      for (int n = 0; n < 3000 && done_cnt == d0; n++) begin
         bus.start = 1'b0;
         if (inject && !inj && bus.dp_op == 3'd3) begin
            bus.start = 1'b1;
            bus.length = 8'd3;
            inj = 1'b1;
         end
         @(negedge clk); #1;
      end
      bus.start = 1'b0;
      check("done_count", done_cnt - d0, 1);
      exp_done = L == 0 ? 1 + W : 1 + 3 * W + L * (W + 2) + 2 * D;
      exp_res = (L == 0 || exp_ham == exp_spam) ? 3 : exp_ham < exp_spam ? 1 : 0;
      check("done_cycle", done_cyc, exp_done);
      check("result", done_res, exp_res);
      check("busy_done", bus.busy, 1);
      check("n_tokens", tok_q.size(), L);
      for (int i = 0; i < L && i < tok_q.size(); i++) begin
         check("token", tok_q[i], tok(mem[i]));
         check("last", lst_q[i], i == L - 1);
      end
   endtask
   initial begin
      int d0;
      for (int i = 0; i < 8; i++) begin
         h_op[i] = 3'd0;
         h_last[i] = 1'b0;
      end
      bus.start = 1'b0;
      bus.length = 8'd0;
      load("");
      repeat (3) @(negedge clk);
      #1;
      check_reset("reset");
      reset = 1'b0;
      @(negedge clk); #1;
      check_reset("idle");
      run(0, 0, 0, 0, 0);
      load("Ab7!");
      run(4, -5, 3, 9, 0);
      run(4, -5, 9, 3, 0);
      run(4, -5, 6, 6, 0);
      for (int k = 0; k < 6; k++) begin
         load("");
         run(int'($urandom_range(1, 10)), RND, RND, RND, 0);
      end
      load("");
      run(255, RND, RND, RND, 0);
      load("hello world");
      @(negedge clk); #1;
      tok_q.delete();
      bus.start = 1'b1;
      bus.length = 8'd11;
      t0 = cyc;
      d0 = done_cnt;
      @(negedge clk); #1;
      bus.start = 1'b0;
      for (int n = 0; n < 500 && tok_q.size() < 3; n++) begin
         @(negedge clk); #1;
      end
      check("mid_add", bus.dp_op, 2);
      reset = 1'b1;
      @(negedge clk); #1;
      check_reset("abort");
      reset = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      check("no_done", done_cnt, d0);
      run(11, RND, RND, RND, 0);
      load("Hi!");
      run(3, RND, RND, RND, 1);
      run(3, 2, 5, 5, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
